// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer around one shared 4-bit combinational adder.
// Processes one nibble per clock, least-significant nibble first, and reports the result with a start/done handshake.
module nibble_serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_Result,
    output logic             o_Cout,
    output logic             o_Overflow,
    output logic [3:0]       o_fa_A,
    output logic [3:0]       o_fa_B,
    output logic             o_fa_Cin,
    input  logic [3:0]       i_fa_Sum,
    input  logic             i_fa_Cout
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-5:0]   res_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx;
    logic               last_c;

    assign last_c = (idx == IDX_W'(NIBBLES - 1));

    // Next-state and adder operand steering
    always_comb begin
        state_next = state;
        o_fa_A     = 4'h0;
        o_fa_B     = 4'h0;
        o_fa_Cin   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_next = RUN;
            end
            RUN: begin
                o_fa_A   = a_r[{idx, 2'b00} +: 4];
                o_fa_B   = b_r[{idx, 2'b00} +: 4];
                o_fa_Cin = carry_r;
                if (last_c) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            res_r      <= '0;
            carry_r    <= 1'b0;
            idx        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_Result   <= '0;
            o_Cout     <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            state  <= state_next;
            o_busy <= (state_next == RUN);
            o_done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_r     <= i_A;
                        b_r     <= i_mode ? ~i_B : i_B;
                        carry_r <= i_mode;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    // Lower nibbles shift in from the top; the last nibble goes straight to the output
                    res_r   <= {i_fa_Sum, res_r[WIDTH-5:4]};
                    carry_r <= i_fa_Cout;
                    idx     <= idx + 1'b1;
                    if (last_c) begin
                        o_Result   <= {i_fa_Sum, res_r};
                        o_Cout     <= i_fa_Cout;
                        o_Overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                      (i_fa_Sum[3] != a_r[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for nibble_serial_addsub_ctrl: directed corner cases plus random operations.
// A behavioural 4-bit adder is wired in, and a behavioural arithmetic reference model checks each result.
module tb_nibble_serial_addsub_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic [3:0]       fa_a;
    logic [3:0]       fa_b;
    logic             fa_cin;
    logic [3:0]       fa_sum;
    logic             fa_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External combinational 4-bit full adder
    assign {fa_cout, fa_sum} = 5'(fa_a) + 5'(fa_b) + 5'(fa_cin);

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_mode     (mode),
        .i_A        (a_in),
        .i_B        (b_in),
        .o_busy     (busy),
        .o_done     (done),
        .o_Result   (result),
        .o_Cout     (cout),
        .o_Overflow (overflow),
        .o_fa_A     (fa_a),
        .o_fa_B     (fa_b),
        .o_fa_Cin   (fa_cin),
        .i_fa_Sum   (fa_sum),
        .i_fa_Cout  (fa_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Run one operation; optionally poke i_start with junk operands in cycles 2 and 5
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m, input bit poke);
        int          s;
        logic [16:0] full;
        logic [15:0] exp_res;
        logic        exp_cout;
        logic        exp_ovf;
        logic [15:0] bx;
        if (m) begin
            exp_res  = a - b;
            exp_cout = (a >= b);
            s        = int'($signed(a)) - int'($signed(b));
        end else begin
            full     = 17'(a) + 17'(b);
            exp_res  = full[15:0];
            exp_cout = full[16];
            s        = int'($signed(a)) + int'($signed(b));
        end
        exp_ovf = (s > 32767) || (s < -32768);
        bx      = m ? ~b : b;

        start = 1'b1; a_in = a; b_in = b; mode = m;
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            start = (poke && c == 2);
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
            mode  = 1'($urandom);
            check("busy_run", 32'(busy), 32'd1);
            check("done_run", 32'(done), 32'd0);
            check("fa_a", 32'(fa_a), 32'(a[4*(c-1) +: 4]));
            check("fa_b", 32'(fa_b), 32'(bx[4*(c-1) +: 4]));
            if (c == 1) check("fa_cin", 32'(fa_cin), 32'(m));
            next_cycle();
        end
        start = poke;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(exp_res));
        check("cout", 32'(cout), 32'(exp_cout));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        next_cycle();
        start = 1'b0;
        check("done_after", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("result_held", 32'(result), 32'(exp_res));
        check("fa_a_idle", 32'(fa_a), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; a_in = '0; b_in = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        next_cycle();

        run_op(16'h1234, 16'h0FF9, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0009, 1'b1, 1'b0);
        run_op(16'h0009, 16'h0005, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        run_op(16'hABCD, 16'h1357, 1'b0, 1'b1);

        // Reset in cycle 3 of an operation aborts it without a done pulse
        start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; mode = 1'b0;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end
        run_op(16'h4321, 16'h1111, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
